if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Fetch-stage producer that drives the IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Buffers each returned instruction and generates the IF/ID write enable (flag) and squash (pc_replace) controls.
- Handles branch redirects from EX and load-use stalls from the hazard unit, including discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, ADDI x0,x0,0 presented whenever no valid instruction is available.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock, sampled on posedge clk.
- stall  in  1  hazard unit: ID cannot accept a new instruction this cycle.
- redirect_valid  in  1  EX: branch/jump taken, fetch must restart.
- redirect_addr  in  32  target PC, valid with redirect_valid.
- imem_req  out  1  one-cycle request pulse to instruction memory.
- imem_addr  out  32  word address for the request, valid with imem_req.
- imem_rvalid  in  1  response strobe, latency ≥1 cycle after imem_req.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- instruction_read  out  32  instruction presented to IF/ID.
- instruction_addr  out  32  PC of instruction_read.
- flag  out  1  IF/ID write enable.
- pc_replace  out  1  IF/ID squash: latch NOP instead of instruction_read.

Behaviour:
- States: S_ISSUE, S_WAIT, S_HOLD. Registers: pc, buf_instr, buf_addr, kill.
- Reset (synchronous): state=S_ISSUE, pc=RESET_PC, buf_instr=NOP_INSTR, buf_addr=RESET_PC, kill=0.
- While reset is high, outputs are forced: imem_req=0, flag=0, pc_replace=1, instruction_read=NOP_INSTR, instruction_addr=RESET_PC.
- Output decode:
  - In S_HOLD: instruction_read=buf_instr, instruction_addr=buf_addr.
  - In all other states: instruction_read=NOP_INSTR, instruction_addr=pc.
  - flag = ~stall | redirect_valid. Redirect overrides stall.
  - pc_replace = (state!=S_HOLD) | redirect_valid. Absent instructions become bubbles.
- S_ISSUE:
  - If redirect_valid: imem_req=0, pc<=redirect_addr, stay in S_ISSUE.
  - Otherwise: imem_req=1, imem_addr=pc, go to S_WAIT.
- S_WAIT:
  - If redirect_valid: pc<=redirect_addr, kill<=1.
  - On imem_rvalid with (kill | redirect_valid): discard the response, kill<=0, go to S_ISSUE.
  - On imem_rvalid otherwise: buf_instr<=imem_rdata, buf_addr<=pc, pc<=pc+4, go to S_HOLD.
  - Without imem_rvalid, remain in S_WAIT indefinitely; there is no timeout.
- S_HOLD:
  - If redirect_valid: drop the buffered instruction, pc<=redirect_addr, go to S_ISSUE.
  - Else if ~stall: the instruction is consumed this edge. Same cycle: imem_req=1, imem_addr=pc, go to S_WAIT.
  - Else: hold the buffer and outputs unchanged.
- Throughput and latency:
  - Peak rate is 1 instruction per 2 cycles with 1-cycle memory.
  - Redirect-to-first-request latency: 1 cycle from S_HOLD/S_ISSUE. From S_WAIT it is the remaining memory latency plus 1.
- PC arithmetic: 32-bit, pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0). redirect_addr[1:0] is used as given and is not checked.
- imem_rvalid outside S_WAIT is ignored.
- Back-to-back redirects: the last one wins; kill remains set.
- Reset mid-request: state returns to S_ISSUE with kill=0. The memory must not return a response for a request issued before reset. That is a system-level contract and is asserted in the bench.

Decomposition:
- Shared riscv_pkg holds NOP_INSTR (32'h0000_0013), PC_STEP (4), and the fetch_state_t enum {S_ISSUE, S_WAIT, S_HOLD}. The fetch_state_t enum is exported for hazard-unit debug.
- No sub-module. The FSM, PC register and single-entry buffer are one block of roughly 150 lines.

Test Plan:
- Reset, then 1-cycle memory returning 32'h00A00093 at addr 0 -> imem_req at cycle 1 with addr 0. S_HOLD at cycle 3 presents instr 32'h00A00093/addr 0 with flag=1, pc_replace=0. Next request uses addr 4.
- stall=1 for 3 cycles while in S_HOLD -> flag=0 and outputs stable for those cycles. No imem_req until stall drops, then the request goes to the next PC.
- redirect_valid with redirect_addr=32'h100 while in S_WAIT with 3-cycle latency -> returned word is discarded and flag=1/pc_replace=1 that cycle. The next imem_addr=32'h100.
- redirect and stall both high in S_HOLD -> flag=1, pc_replace=1. The next cycle issues imem_addr=redirect_addr.
- pc=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000.
- reset asserted while in S_WAIT -> outputs go to reset values the next cycle. The first post-reset imem_addr=RESET_PC and no stale response is consumed.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: NOP encoding, PC step and the fetch FSM state type.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Exported so the hazard unit can observe fetch progress for debug.
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request in flight, buffers the returned word and
// drives the IF/ID write-enable (flag) and squash (pc_replace) controls.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_addr_i,
  if_fetch_unit_if.master        imem_if,
  output logic [31:0]            instruction_read_o,
  output logic [31:0]            instruction_addr_o,
  output logic                   flag_o,
  output logic                   pc_replace_o
);

  import riscv_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_addr_q, buf_addr_d;
  logic         kill_q, kill_d;
  logic         req;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_addr_d  = buf_addr_q;
    kill_d      = kill_q;
    req         = 1'b0;

    unique case (state_q)
      S_ISSUE: begin
        if (redirect_valid_i) begin
          pc_d = redirect_addr_i;
        end else begin
          req     = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid_i) begin
          pc_d   = redirect_addr_i;
          kill_d = 1'b1;
        end
        if (imem_if.imem_rvalid) begin
          // A response for a request made before a redirect is stale: drop it and refetch.
          if (kill_q || redirect_valid_i) begin
            kill_d  = 1'b0;
            state_d = S_ISSUE;
          end else begin
            buf_instr_d = imem_if.imem_rdata;
            buf_addr_d  = pc_q;
            pc_d        = pc_q + PC_STEP;
            state_d     = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid_i) begin
          pc_d    = redirect_addr_i;
          state_d = S_ISSUE;
        end else if (!stall_i) begin
          // Buffer is consumed this edge, so the next request can go out in the same cycle.
          req     = 1'b1;
          state_d = S_WAIT;
        end
      end

      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_ISSUE;
      pc_q        <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_addr_q  <= RESET_PC;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_addr_q  <= buf_addr_d;
      kill_q      <= kill_d;
    end
  end

  always_comb begin
    imem_if.imem_req  = req && !reset_i;
    imem_if.imem_addr = pc_q;

    if (reset_i) begin
      instruction_read_o = NOP_INSTR;
      instruction_addr_o = RESET_PC;
      flag_o             = 1'b0;
      pc_replace_o       = 1'b1;
    end else begin
      if (state_q == S_HOLD) begin
        instruction_read_o = buf_instr_q;
        instruction_addr_o = buf_addr_q;
      end else begin
        instruction_read_o = NOP_INSTR;
        instruction_addr_o = pc_q;
      end
      flag_o       = !stall_i || redirect_valid_i;
      pc_replace_o = (state_q != S_HOLD) || redirect_valid_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit against a transaction-level fetch model and imem model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic [31:0] instruction_read, instruction_addr;
  logic        flag, pc_replace;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) u_dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .stall_i            (stall),
    .redirect_valid_i   (redirect_valid),
    .redirect_addr_i    (redirect_addr),
    .imem_if            (imem_bus),
    .instruction_read_o (instruction_read),
    .instruction_addr_o (instruction_addr),
    .flag_o             (flag),
    .pc_replace_o       (pc_replace)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Fetch model: an outstanding request, whether it will be thrown away, and a held instruction.
  bit          m_busy = 0, m_discard = 0, m_held = 0;
  logic [31:0] m_pc = RESET_PC, m_hinstr = NOP, m_haddr = RESET_PC;

  // Memory model.
  bit          pend = 0;
  logic [31:0] pend_addr = 0;
  int          resp_cyc = 0, cyc = 0, fixed_lat = 1;
  int          rst_epoch = 0, pend_epoch = 0;

  // Last sampled DUT outputs.
  logic        s_req, s_flag, s_repl;
  logic [31:0] s_addr, s_instr, s_iaddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] ra);
    logic        exp_req, exp_flag, exp_repl, delivered;
    logic [31:0] exp_instr, exp_iaddr, req_pc, tmp;
    @(negedge clk);
    reset          = rst;
    stall          = st;
    redirect_valid = rv;
    redirect_addr  = ra;
    tmp            = $urandom();
    delivered      = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = tmp;
    if (!rst && pend && cyc >= resp_cyc) begin
      assert (pend_epoch == rst_epoch) else $error("imem responded to a pre-reset request");
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = mem_word(pend_addr);
      delivered            = 1'b1;
    end else if (!rst && !pend && $urandom_range(7) == 0) begin
      imem_bus.imem_rvalid = 1'b1;  // stray strobe that must be ignored
    end
    #1;
    exp_req   = !rst && !rv && (m_held ? !st : !m_busy);
    exp_instr = rst ? NOP : (m_held ? m_hinstr : NOP);
    exp_iaddr = rst ? RESET_PC : (m_held ? m_haddr : m_pc);
    exp_flag  = rst ? 1'b0 : (!st || rv);
    exp_repl  = rst ? 1'b1 : (!m_held || rv);

    s_req   = imem_bus.imem_req;
    s_addr  = imem_bus.imem_addr;
    s_instr = instruction_read;
    s_iaddr = instruction_addr;
    s_flag  = flag;
    s_repl  = pc_replace;

    check_eq("imem_req", 32'(s_req), 32'(exp_req));
    if (exp_req) check_eq("imem_addr", s_addr, m_pc);
    check_eq("instruction_read", s_instr, exp_instr);
    check_eq("instruction_addr", s_iaddr, exp_iaddr);
    check_eq("flag", 32'(s_flag), 32'(exp_flag));
    check_eq("pc_replace", 32'(s_repl), 32'(exp_repl));

    req_pc = m_pc;
    if (rst) begin
      m_busy = 0; m_discard = 0; m_held = 0; m_pc = RESET_PC;
      pend = 0;
      rst_epoch++;
    end else begin
      if (rv) begin
        m_pc   = ra;
        m_held = 0;
        if (m_busy) begin
          if (imem_bus.imem_rvalid) begin
            m_busy = 0; m_discard = 0;
          end else begin
            m_discard = 1;
          end
        end
      end else if (m_busy) begin
        if (imem_bus.imem_rvalid) begin
          if (!m_discard) begin
            m_held   = 1;
            m_hinstr = imem_bus.imem_rdata;
            m_haddr  = m_pc;
            m_pc     = m_pc + 32'd4;
          end
          m_busy = 0; m_discard = 0;
        end
      end else if (exp_req) begin
        m_held = 0;
        m_busy = 1;
      end
      if (delivered) pend = 0;
      if (exp_req) begin
        pend       = 1;
        pend_addr  = req_pc;
        pend_epoch = rst_epoch;
        resp_cyc   = cyc + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(3, 1)));
      end
    end
    cyc++;
  endtask

  task automatic run_until_held(input int bound);
    int n = 0;
    while (!m_held && n < bound) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    if (!m_held) begin
      n_tests++;
      n_fail++;
      $display("FAIL held_timeout: got no instruction within %0d cycles", bound);
    end
  endtask

  task automatic run_until_req(input int bound);
    int n = 0;
    do begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end while (!s_req && n < bound);
  endtask

  initial begin
    logic [31:0] ra;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;

    // Reset, then a 1-cycle memory returning the word at address 0.
    fixed_lat = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("rst_flag", 32'(s_flag), 32'd0);
    check_eq("rst_iaddr", s_iaddr, RESET_PC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("c1_req", 32'(s_req), 32'd1);
    check_eq("c1_addr", s_addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("c3_instr", s_instr, 32'h00A0_0093);
    check_eq("c3_repl", 32'(s_repl), 32'd0);
    check_eq("c3_next_addr", s_addr, 32'h4);

    // Stall three cycles in hold.
    run_until_held(10);
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("stall_flag", 32'(s_flag), 32'd0);
      check_eq("stall_req", 32'(s_req), 32'd0);
      check_eq("stall_instr", s_instr, mem_word(32'h4));
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("unstall_addr", s_addr, 32'h8);

    // Redirect while waiting on a 3-cycle memory.
    fixed_lat = 3;
    run_until_held(10);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h100);
    run_until_req(10);
    check_eq("redir_wait_addr", s_addr, 32'h100);

    // Redirect and stall together in hold.
    fixed_lat = 1;
    run_until_held(10);
    step(1'b0, 1'b1, 1'b1, 32'h200);
    check_eq("redir_stall_flag", 32'(s_flag), 32'd1);
    check_eq("redir_stall_repl", 32'(s_repl), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("redir_stall_addr", s_addr, 32'h200);

    // PC wraps past the top of the address space.
    run_until_held(10);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("wrap_req_addr", s_addr, 32'hFFFF_FFFC);
    run_until_held(10);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("wrap_iaddr", s_iaddr, 32'hFFFF_FFFC);
    check_eq("wrap_next_addr", s_addr, 32'h0);

    // Reset while a request is in flight.
    fixed_lat = 3;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("midrst_instr", s_instr, NOP);
    check_eq("midrst_repl", 32'(s_repl), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("postrst_addr", s_addr, RESET_PC);
    repeat (8) step(1'b0, 1'b0, 1'b0, 32'h0);

    // Random traffic with random memory latency.
    fixed_lat = 0;
    repeat (3000) begin
      ra = $urandom();
      ra[1:0] = 2'b00;
      if ($urandom_range(15) == 0) ra = 32'hFFFF_FFFC;
      step(($urandom_range(99) == 0), ($urandom_range(2) == 0), ($urandom_range(7) == 0), ra);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
